gobou_ctrl: RTL and testbench
=============================

Name: gobou_ctrl

Overview:
- Sequencer directly upstream of gobou_core in the fully-connected accelerator.
- On a request it walks the image memory and weight memory for one FC layer, and drives the core's clear, MAC-enable and bias strobes.
- It then writes the core outputs back to image memory, processing output neurons in groups of CORE.
- Raises ack when the whole layer is complete.

Parameters:
- CORE, 8: parallel neurons in gobou_core (power of 2).
- IMGSIZE, 12: image memory address width.
- NETSIZE, 14: weight memory address width; one word holds CORE weights.
- LWIDTH, 10: width of layer size fields.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  1  start pulse; sampled only while ack=1.
- in_size  in  LWIDTH  inputs per neuron.
- out_size  in  LWIDTH  neurons in layer.
- in_offset  in  IMGSIZE  image address of input 0.
- out_offset  in  IMGSIZE  image address of output 0.
- net_offset  in  NETSIZE  weight address of group 0 word 0.
- ack  out  1  high when idle or done.
- mem_img_addr  out  IMGSIZE  image memory address.
- mem_img_we  out  1  image memory write enable.
- mem_net_addr  out  NETSIZE  weight memory address.
- core_clear  out  1  clears core accumulators.
- core_mac  out  1  core accumulates the current input×weight.
- core_bias  out  1  core adds the current weight word as bias.
- out_sel  out  $clog2(CORE)  core lane driving write data.

Behaviour:
- Reset (rst=1 at an edge, at any time including mid-layer):
  - Next cycle: ack=1; all other outputs 0; state IDLE.
  - Any in-flight layer is abandoned with no further writes.
- IDLE:
  - req=1 latches all size/offset inputs, sets group base o=0 and ack<=0, and goes to CLEAR.
  - req while ack=0 is ignored.
  - If latched in_size=0 or out_size=0: go straight back to IDLE; ack=1 again the cycle after; no strobes, no writes.
- CLEAR, 1 cycle:
  - core_clear=1; input index i<=0.
  - Next state MAC.
- MAC, in_size cycles:
  - mem_img_addr = in_offset+i.
  - mem_net_addr = net_offset + g*(in_size+1) + i, where g is the group number.
  - i increments each cycle; after the i=in_size-1 cycle, go to BIAS.
- Memory read latency is 1 cycle, so core_mac is the MAC-state indicator delayed by one register.
  - core_mac is high for exactly in_size consecutive cycles, starting the cycle after MAC entry.
- BIAS, 1 cycle:
  - mem_net_addr = net_offset + g*(in_size+1) + in_size.
  - The last core_mac pulse occurs in this cycle.
  - Next state BIASW.
- BIASW, 1 cycle:
  - core_bias=1; core_mac=0.
  - Next state WB.
- WB, n = min(CORE, out_size-o) cycles:
  - For k = 0..n-1: mem_img_we=1, mem_img_addr = out_offset+o+k, out_sel=k.
  - After the last write:
    - If o+CORE < out_size: o<=o+CORE, g<=g+1, go to CLEAR.
    - Otherwise go to IDLE; ack=1 the following cycle.
- Outside their states:
  - mem_img_we=0, core_clear=0, core_bias=0.
  - Addresses and out_sel hold their last value.
- Cycles with ack=0 per layer = sum over groups of (1 + in_size + 2 + n).
- Arithmetic:
  - Address sums wrap modulo 2^IMGSIZE or 2^NETSIZE.
  - Counters are LWIDTH wide; the group product is computed at NETSIZE width.
- Only one of core_clear, core_bias or mem_img_we is high in any cycle.
- core_mac never overlaps core_clear or core_bias.

Test Plan:
- Reset, then idle 5 cycles -> ack=1; all strobes, mem_img_we and out_sel are 0.
- in_size=4, out_size=8, in_offset=0x100, out_offset=0x200, net_offset=0, req pulse:
  - ack low for exactly 15 cycles.
  - core_mac high 4 cycles; image addresses 0x100–0x103; net addresses 0–3, then bias at 4.
  - 8 writes to 0x200–0x207 with out_sel 0–7.
- in_size=4, out_size=10:
  - ack low for 24 cycles.
  - Group 1 net addresses 5–8, bias 9.
  - Final group writes only 0x208–0x209 with out_sel 0–1.
- in_size=1, out_size=1:
  - core_mac one pulse; one write at out_offset.
  - ack low for 5 cycles.
- req reasserted every cycle during the 15-cycle layer -> no restart; write count still 8.
- in_size=0 -> ack low 1 cycle, zero writes.
- rst asserted during MAC of the in_size=4, out_size=10 layer -> next cycle ack=1, all strobes 0, no further writes.
  - Fresh req then completes normally with the original cycle count.

Source files
------------

// File: rtl/gobou_ctrl.sv
// Sequencer for gobou_core: walks image/weight memory for one FC layer, strobes the core,
// then writes each group of CORE output neurons back to image memory.
module gobou_ctrl #(
    parameter int CORE    = 8,
    parameter int IMGSIZE = 12,
    parameter int NETSIZE = 14,
    parameter int LWIDTH  = 10,
    localparam int SELW   = (CORE > 1) ? $clog2(CORE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [LWIDTH-1:0]  in_size,
    input  logic [LWIDTH-1:0]  out_size,
    input  logic [IMGSIZE-1:0] in_offset,
    input  logic [IMGSIZE-1:0] out_offset,
    input  logic [NETSIZE-1:0] net_offset,
    output logic               ack,
    output logic [IMGSIZE-1:0] mem_img_addr,
    output logic               mem_img_we,
    output logic [NETSIZE-1:0] mem_net_addr,
    output logic               core_clear,
    output logic               core_mac,
    output logic               core_bias,
    output logic [SELW-1:0]    out_sel
);

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, BIAS, BIASW, WB} state_t;

    localparam logic [LWIDTH:0] CORE_X = (LWIDTH+1)'(CORE);
    localparam logic [LWIDTH:0] ONE_X  = (LWIDTH+1)'(1);
    localparam logic [SELW-1:0] K_LAST = SELW'(CORE - 1);

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic               mac_q;
    logic [LWIDTH-1:0]  in_size_q, in_size_d, out_size_q, out_size_d;
    logic [IMGSIZE-1:0] in_off_q, in_off_d, out_off_q, out_off_d;
    logic [NETSIZE-1:0] net_base_q, net_base_d;
    logic [LWIDTH-1:0]  i_q, i_d, o_q, o_d;
    logic [SELW-1:0]    k_q, k_d;
    logic [IMGSIZE-1:0] img_addr_q, img_addr_d;
    logic [NETSIZE-1:0] net_addr_q, net_addr_d;
    logic [SELW-1:0]    sel_q, sel_d;

    logic accept, zero_layer, last_in, last_wr, more_groups;

    assign accept      = (state_q == IDLE) && ack_q && req;
    assign zero_layer  = (in_size == '0) || (out_size == '0);
    assign last_in     = (i_q == in_size_q - 1'b1);
    // Group-end tests run one bit wider so o+CORE cannot wrap near the top of the range.
    assign last_wr     = (k_q == K_LAST) ||
                         ({1'b0, o_q} + (LWIDTH+1)'(k_q) + ONE_X == {1'b0, out_size_q});
    assign more_groups = ({1'b0, o_q} + CORE_X) < {1'b0, out_size_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b1;
            mac_q      <= 1'b0;
            img_addr_q <= '0;
            net_addr_q <= '0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            mac_q      <= (state_q == MAC);
            img_addr_q <= img_addr_d;
            net_addr_q <= net_addr_d;
            sel_q      <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        in_size_q  <= in_size_d;
        out_size_q <= out_size_d;
        in_off_q   <= in_off_d;
        out_off_q  <= out_off_d;
        net_base_q <= net_base_d;
        i_q        <= i_d;
        o_q        <= o_d;
        k_q        <= k_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = zero_layer ? IDLE : CLEAR;
            CLEAR:   state_d = MAC;
            MAC:     if (last_in) state_d = BIAS;
            BIAS:    state_d = BIASW;
            BIASW:   state_d = WB;
            WB:      if (last_wr) state_d = more_groups ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d      = ack_q;
        in_size_d  = in_size_q;
        out_size_d = out_size_q;
        in_off_d   = in_off_q;
        out_off_d  = out_off_q;
        net_base_d = net_base_q;
        i_d        = i_q;
        o_d        = o_q;
        k_d        = k_q;
        case (state_q)
            IDLE: begin
                ack_d = !accept;
                if (accept) begin
                    in_size_d  = in_size;
                    out_size_d = out_size;
                    in_off_d   = in_offset;
                    out_off_d  = out_offset;
                    net_base_d = net_offset;
                    o_d        = '0;
                end
            end
            CLEAR: i_d = '0;
            MAC:   i_d = i_q + 1'b1;
            BIASW: k_d = '0;
            WB: begin
                k_d = k_q + 1'b1;
                if (last_wr) begin
                    if (more_groups) begin
                        o_d        = o_q + LWIDTH'(CORE);
                        net_base_d = net_base_q + NETSIZE'(in_size_q) + 1'b1;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Addresses and lane select hold their last value outside the states that drive them.
    always_comb begin
        img_addr_d = img_addr_q;
        net_addr_d = net_addr_q;
        sel_d      = sel_q;
        case (state_q)
            MAC: begin
                img_addr_d = in_off_q + IMGSIZE'(i_q);
                net_addr_d = net_base_q + NETSIZE'(i_q);
            end
            BIAS: net_addr_d = net_base_q + NETSIZE'(in_size_q);
            WB: begin
                img_addr_d = out_off_q + IMGSIZE'(o_q) + IMGSIZE'(k_q);
                sel_d      = k_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        ack          = ack_q;
        core_clear   = (state_q == CLEAR);
        core_bias    = (state_q == BIASW);
        mem_img_we   = (state_q == WB);
        core_mac     = mac_q;
        mem_img_addr = img_addr_d;
        mem_net_addr = net_addr_d;
        out_sel      = sel_d;
    end

endmodule

// File: tb/tb_gobou_ctrl.sv
// Randomised bench for gobou_ctrl: a per-layer list of expected cycles is built from the
// layer rules (groups, MAC/bias/writeback phases) and compared cycle by cycle.
module tb_gobou_ctrl;

    localparam int CORE = 8, IMGSIZE = 12, NETSIZE = 14, LWIDTH = 10;
    localparam int IM = (1 << IMGSIZE) - 1;
    localparam int NM = (1 << NETSIZE) - 1;

    logic clk = 1'b0, rst = 1'b1, req = 1'b0;
    logic [LWIDTH-1:0] in_size = '0, out_size = '0;
    logic [IMGSIZE-1:0] in_offset = '0, out_offset = '0;
    logic [NETSIZE-1:0] net_offset = '0;
    logic ack, mem_img_we, core_clear, core_mac, core_bias;
    logic [IMGSIZE-1:0] mem_img_addr;
    logic [NETSIZE-1:0] mem_net_addr;
    logic [2:0] out_sel;

    int checks = 0, failures = 0;

    gobou_ctrl #(.CORE(CORE), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE), .LWIDTH(LWIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .in_size(in_size), .out_size(out_size),
        .in_offset(in_offset), .out_offset(out_offset), .net_offset(net_offset),
        .ack(ack), .mem_img_addr(mem_img_addr), .mem_img_we(mem_img_we),
        .mem_net_addr(mem_net_addr), .core_clear(core_clear), .core_mac(core_mac),
        .core_bias(core_bias), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr, mac, bias, we;
        int img, net, sel;   // -1 = not constrained this cycle
    } cyc_t;

    cyc_t expq[$];
    int exp_wr, exp_mac;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(bit clr, bit mac, bit bias, bit we, int img, int net, int sel);
        cyc_t c;
        c.clr = clr; c.mac = mac; c.bias = bias; c.we = we;
        c.img = img; c.net = net; c.sel = sel;
        expq.push_back(c);
    endfunction

    // Expected ack-low cycles of one layer, straight from the group/phase rules.
    function automatic void build(int in_s, int out_s, int io, int oo, int no);
        expq.delete();
        exp_wr = 0;
        exp_mac = 0;
        if (in_s == 0 || out_s == 0) begin
            push(0, 0, 0, 0, -1, -1, -1);
            return;
        end
        for (int o = 0; o < out_s; o += CORE) begin
            int base = no + (o / CORE) * (in_s + 1);
            int n = (out_s - o < CORE) ? out_s - o : CORE;
            push(1, 0, 0, 0, -1, -1, -1);
            for (int j = 0; j < in_s; j++)
                push(0, j > 0, 0, 0, (io + j) & IM, (base + j) & NM, -1);
            push(0, 1, 0, 0, -1, (base + in_s) & NM, -1);
            push(0, 0, 1, 0, -1, -1, -1);
            for (int k = 0; k < n; k++)
                push(0, 0, 0, 1, (oo + o + k) & IM, -1, k);
            exp_wr += n;
            exp_mac += in_s;
        end
    endfunction

    task automatic run_layer(input int in_s, input int out_s, input int io, input int oo,
                             input int no, input bit hold);
        int low = 0, macs = 0, wrs = 0;
        build(in_s, out_s, io, oo, no);
        @(negedge clk);
        in_size = LWIDTH'(in_s); out_size = LWIDTH'(out_s);
        in_offset = IMGSIZE'(io); out_offset = IMGSIZE'(oo); net_offset = NETSIZE'(no);
        req = 1'b1;
        @(negedge clk);
        if (!hold) req = 1'b0;
        // Scramble the inputs: the layer must run on the latched copies.
        in_size = LWIDTH'($urandom); out_size = LWIDTH'($urandom);
        in_offset = IMGSIZE'($urandom); out_offset = IMGSIZE'($urandom);
        net_offset = NETSIZE'($urandom);
        foreach (expq[c]) begin
            cyc_t e = expq[c];
            chk("ack_busy", int'(ack), 0);
            chk("clear", int'(core_clear), int'(e.clr));
            chk("mac", int'(core_mac), int'(e.mac));
            chk("bias", int'(core_bias), int'(e.bias));
            chk("we", int'(mem_img_we), int'(e.we));
            if (e.img >= 0) chk("img_addr", int'(mem_img_addr), e.img);
            if (e.net >= 0) chk("net_addr", int'(mem_net_addr), e.net);
            if (e.sel >= 0) chk("out_sel", int'(out_sel), e.sel);
            low += (ack == 1'b0) ? 1 : 0;
            macs += int'(core_mac);
            wrs += int'(mem_img_we);
            @(negedge clk);
        end
        req = 1'b0;
        for (int x = 0; x < 64 && ack == 1'b0; x++) begin
            low++;
            macs += int'(core_mac);
            wrs += int'(mem_img_we);
            @(negedge clk);
        end
        chk("ack_low_cycles", low, expq.size());
        chk("ack_done", int'(ack), 1);
        chk("idle_strobes", int'({core_clear, core_mac, core_bias, mem_img_we}), 0);
        chk("write_count", wrs, exp_wr);
        chk("mac_count", macs, exp_mac);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_ack", int'(ack), 1);
        chk("rst_strobes", int'({core_clear, core_mac, core_bias, mem_img_we}), 0);
        chk("rst_out_sel", int'(out_sel), 0);
        chk("rst_img_addr", int'(mem_img_addr), 0);
        chk("rst_net_addr", int'(mem_net_addr), 0);

        run_layer(4, 8, 'h100, 'h200, 0, 1'b0);
        run_layer(4, 10, 'h100, 'h200, 0, 1'b0);
        run_layer(1, 1, 'h010, 'h300, 'h20, 1'b0);
        run_layer(4, 8, 'h100, 'h200, 0, 1'b1);
        run_layer(0, 8, 'h100, 'h200, 0, 1'b0);
        run_layer(3, 0, 'h100, 'h200, 0, 1'b0);

        // Reset in the middle of the MAC phase of a two-group layer.
        begin
            int wrs = 0;
            @(negedge clk);
            in_size = 4; out_size = 10; in_offset = 'h100; out_offset = 'h200; net_offset = 0;
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            repeat (2) @(negedge clk);
            chk("mid_mac_active", int'(core_mac), 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("midrst_ack", int'(ack), 1);
            chk("midrst_strobes", int'({core_clear, core_mac, core_bias, mem_img_we}), 0);
            chk("midrst_out_sel", int'(out_sel), 0);
            for (int x = 0; x < 30; x++) begin
                wrs += int'(mem_img_we);
                @(negedge clk);
            end
            chk("midrst_no_writes", wrs, 0);
        end
        run_layer(4, 10, 'h100, 'h200, 0, 1'b0);

        // Randomised layers, offsets anywhere so address wrap is exercised.
        for (int t = 0; t < 25; t++)
            run_layer($urandom_range(0, 6), $urandom_range(0, 20), $urandom_range(0, IM),
                      $urandom_range(0, IM), $urandom_range(0, NM), 1'($urandom_range(0, 1)));
        run_layer(2, 17, IM - 1, IM - 3, NM - 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
